// File: rtl/region_switch_ctrl_pkg.sv
// Shared types for the region switch controller: button bit map, FSM states, combo decode.
package region_switch_ctrl_pkg;

  localparam int unsigned BTN_W = 12;
  localparam int unsigned RW    = 2;

  localparam int unsigned BTN_B      = 0;
  localparam int unsigned BTN_Y      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;
  localparam int unsigned BTN_A      = 8;
  localparam int unsigned BTN_X      = 9;
  localparam int unsigned BTN_L      = 10;
  localparam int unsigned BTN_R      = 11;

  typedef logic [BTN_W-1:0] buttons_t;
  typedef logic [RW-1:0]    region_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_FIRE,
    ST_RST,
    ST_WAIT_REL
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } combo_t;

  // A combo needs every modifier held plus exactly one d-pad direction.
  function automatic combo_t decode_combo(buttons_t b, buttons_t mask);
    combo_t     c;
    logic [3:0] d;
    d       = {b[BTN_RIGHT], b[BTN_LEFT], b[BTN_DOWN], b[BTN_UP]};
    c.valid = ((b & mask) == mask) && $onehot(d);
    c.dir   = DIR_UP;
    if (d[1]) c.dir = DIR_DOWN;
    if (d[2]) c.dir = DIR_LEFT;
    if (d[3]) c.dir = DIR_RIGHT;
    return c;
  endfunction

endpackage

// File: rtl/region_switch_ctrl_if.sv
// Pad, cartridge and status signals of the region switch controller.
interface region_switch_ctrl_if;
  import region_switch_ctrl_pkg::*;

  logic     gamepad_clk;
  logic     gamepad_latch;
  logic     gamepad_data;
  logic     cart_valid;
  region_t  cart_region;
  region_t  region_out;
  logic     auto_mode;
  logic     d4_en;
  logic     cic_reset;
  logic [1:0] led;

  modport master (
    output gamepad_clk, gamepad_latch, gamepad_data, cart_valid, cart_region,
    input  region_out, auto_mode, d4_en, cic_reset, led
  );

  modport slave (
    input  gamepad_clk, gamepad_latch, gamepad_data, cart_valid, cart_region,
    output region_out, auto_mode, d4_en, cic_reset, led
  );
endinterface

// File: rtl/region_switch_ctrl_gamepad_rx.sv
// SNES pad serial receiver: synchronises the async pad lines and emits one 12-button frame per 16 clocks.
module region_switch_ctrl_gamepad_rx
  import region_switch_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     gamepad_clk,
  input  logic     gamepad_latch,
  input  logic     gamepad_data,
  output logic     frame_valid,
  output buttons_t buttons
);

  logic [2:0] clk_sync;
  logic [2:0] latch_sync;
  logic [1:0] data_sync;
  logic [4:0] bit_cnt;
  buttons_t   shift;
  logic       clk_rise;
  logic       latch_rise;

  assign clk_rise   = clk_sync[1]   & ~clk_sync[2];
  assign latch_rise = latch_sync[1] & ~latch_sync[2];

  // bit_cnt parks at 16 after a full frame so stray clocks cannot start a new one without a latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync    <= '0;
      latch_sync  <= '0;
      data_sync   <= '1;
      bit_cnt     <= 5'd16;
      shift       <= '0;
      buttons     <= '0;
      frame_valid <= 1'b0;
    end else begin
      clk_sync    <= {clk_sync[1:0], gamepad_clk};
      latch_sync  <= {latch_sync[1:0], gamepad_latch};
      data_sync   <= {data_sync[0], gamepad_data};
      frame_valid <= 1'b0;
      if (latch_rise) begin
        bit_cnt <= '0;
      end else if (clk_rise && bit_cnt < 5'd16) begin
        if (bit_cnt < 5'd12) shift[bit_cnt[3:0]] <= ~data_sync[1];
        bit_cnt <= bit_cnt + 5'd1;
        if (bit_cnt == 5'd15) begin
          frame_valid <= 1'b1;
          buttons     <= shift;
        end
      end
    end
  end

endmodule

// File: rtl/region_switch_ctrl.sv
// Hold-to-confirm pad combo region selector with CIC reset pulse and D4 patch enable.
// Optional LED blink pattern: define REGION_SWITCH_LED_BLINK_EN.
module region_switch_ctrl
  import region_switch_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 3,
  parameter buttons_t    COMBO_MASK  = 12'hC0C,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned RST_CYCLES  = 2000000,
  parameter int unsigned DEF_REGION  = 0
`ifdef REGION_SWITCH_LED_BLINK_EN
  ,
  parameter int unsigned CLK_HZ      = 21_477_272
`endif
) (
  input logic clk,
  input logic rst,
  region_switch_ctrl_if.slave bus
);

  localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned PW = $clog2(RST_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_FRAMES);
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_CYCLES - 1);
  localparam region_t LAST_REGION = region_t'(NUM_REGIONS - 1);
  localparam region_t DEF         = region_t'(DEF_REGION);

  logic     frame_valid;
  buttons_t buttons;
  combo_t   combo;

  state_t        state;
  dir_t          dir;
  logic [HW-1:0] hold_cnt;
  logic [PW-1:0] pulse_cnt;
  region_t       region_idx;
  region_t       region_eff;
  logic          auto_q;
  logic          d4_q;
  logic          cic_q;

  region_switch_ctrl_gamepad_rx rx (
    .clk          (clk),
    .rst          (rst),
    .gamepad_clk  (bus.gamepad_clk),
    .gamepad_latch(bus.gamepad_latch),
    .gamepad_data (bus.gamepad_data),
    .frame_valid  (frame_valid),
    .buttons      (buttons)
  );

  always_comb combo = decode_combo(buttons, COMBO_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      dir        <= DIR_UP;
      hold_cnt   <= '0;
      pulse_cnt  <= '0;
      region_idx <= DEF;
      auto_q     <= 1'b0;
      d4_q       <= 1'b1;
      cic_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (frame_valid && combo.valid) begin
          state    <= ST_ARM;
          hold_cnt <= HW'(1);
          dir      <= combo.dir;
        end
        ST_ARM: begin
          if (hold_cnt >= HOLD_MAX) begin
            state <= ST_FIRE;
          end else if (frame_valid) begin
            if (combo.valid && combo.dir == dir) begin
              hold_cnt <= hold_cnt + 1'b1;
            end else begin
              state    <= ST_IDLE;
              hold_cnt <= '0;
            end
          end
        end
        ST_FIRE: begin
          hold_cnt <= '0;
          case (dir)
            DIR_RIGHT: begin
              region_idx <= (region_idx == LAST_REGION) ? '0 : region_idx + 1'b1;
              auto_q     <= 1'b0;
            end
            DIR_LEFT: begin
              region_idx <= (region_idx == '0) ? LAST_REGION : region_idx - 1'b1;
              auto_q     <= 1'b0;
            end
            DIR_UP:  auto_q <= ~auto_q;
            default: d4_q   <= ~d4_q;
          endcase
          if (dir == DIR_DOWN) begin
            state <= ST_WAIT_REL;
          end else begin
            state     <= ST_RST;
            cic_q     <= 1'b1;
            pulse_cnt <= '0;
          end
        end
        ST_RST: begin
          if (pulse_cnt == PULSE_LAST) begin
            cic_q <= 1'b0;
            state <= ST_WAIT_REL;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        ST_WAIT_REL: if (frame_valid && (buttons & COMBO_MASK) == '0) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Out-of-range cartridge codes fall back to the manual index.
  always_comb begin
    region_eff = region_idx;
    if (auto_q && bus.cart_valid && int'(bus.cart_region) < int'(NUM_REGIONS))
      region_eff = bus.cart_region;
  end

  assign bus.region_out = region_eff;
  assign bus.auto_mode  = auto_q;
  assign bus.d4_en      = d4_q;
  assign bus.cic_reset  = cic_q;

`ifdef REGION_SWITCH_LED_BLINK_EN
  localparam int unsigned QTR = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam int unsigned TW  = $clog2(QTR + 1);

  logic [TW-1:0] tick;
  logic [3:0]    step;
  logic [3:0]    steps_on;

  // Each quarter-second step alternates on/off for region+1 blinks, then four dark steps.
  always_comb steps_on = {1'b0, region_eff, 1'b0} + 4'd2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= '0;
      step <= '0;
    end else if (tick == TW'(QTR - 1)) begin
      tick <= '0;
      step <= (step >= steps_on + 4'd3) ? '0 : step + 4'd1;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  assign bus.led = {auto_q, (step < steps_on) && !step[0]};
`else
  assign bus.led = region_eff;
`endif

endmodule

// File: tb/tb_region_switch_ctrl.sv
// Directed plus randomized bench for region_switch_ctrl against a frame-level behavioural model.
module tb_region_switch_ctrl;

  localparam int unsigned NR    = 3;
  localparam int unsigned HOLD  = 10;
  localparam int unsigned RSTC  = 40;
  localparam int unsigned DEFR  = 0;
  localparam logic [11:0] MASK  = 12'hC0C;
  localparam logic [11:0] B_UP    = 12'h010;
  localparam logic [11:0] B_DOWN  = 12'h020;
  localparam logic [11:0] B_LEFT  = 12'h040;
  localparam logic [11:0] B_RIGHT = 12'h080;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  region_switch_ctrl_if bus();

  region_switch_ctrl #(
    .NUM_REGIONS(NR),
    .COMBO_MASK (MASK),
    .HOLD_FRAMES(HOLD),
    .RST_CYCLES (RSTC),
    .DEF_REGION (DEFR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Pulse monitor: counts complete cic_reset pulses and their width in clk cycles.
  int pulse_count = 0;
  int last_width  = 0;
  int run         = 0;
  always @(negedge clk) begin
    if (rst) run = 0;
    else if (bus.cic_reset === 1'b1) run++;
    else if (run != 0) begin
      pulse_count++;
      last_width = run;
      run = 0;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Behavioural model state, updated once per complete pad frame.
  int m_idx, m_auto, m_d4, m_hold, m_dir, m_locked, m_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dir_of(logic [11:0] b);
    int n = 0;
    int d = 0;
    if ((b & MASK) != MASK) return 0;
    if (b[4]) begin n++; d = 1; end
    if (b[5]) begin n++; d = 2; end
    if (b[6]) begin n++; d = 3; end
    if (b[7]) begin n++; d = 4; end
    return (n == 1) ? d : 0;
  endfunction

  function automatic int exp_region();
    if (m_auto != 0 && bus.cart_valid && int'(bus.cart_region) < int'(NR)) return int'(bus.cart_region);
    return m_idx;
  endfunction

  task automatic model_reset();
    m_idx = DEFR; m_auto = 0; m_d4 = 1; m_hold = 0; m_dir = 0; m_locked = 0;
  endtask

  task automatic model_frame(input logic [11:0] b, output bit fired);
    int d;
    d = dir_of(b);
    fired = 1'b0;
    if (m_locked != 0) begin
      if ((b & MASK) == 12'h000) m_locked = 0;
    end else if (m_hold == 0) begin
      if (d != 0) begin m_hold = 1; m_dir = d; end
    end else if (d == m_dir) begin
      m_hold++;
    end else begin
      m_hold = 0;
    end
    if (m_locked == 0 && m_hold == int'(HOLD)) begin
      case (m_dir)
        1: m_auto = (m_auto != 0) ? 0 : 1;
        2: m_d4 = (m_d4 != 0) ? 0 : 1;
        3: begin m_idx = (m_idx + NR - 1) % NR; m_auto = 0; end
        default: begin m_idx = (m_idx + 1) % NR; m_auto = 0; end
      endcase
      m_hold = 0;
      m_locked = 1;
      if (m_dir != 2) begin m_pulses++; fired = 1'b1; end
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " region_out"}, 32'(bus.region_out), exp_region());
    check({tag, " auto_mode"},  32'(bus.auto_mode), m_auto);
    check({tag, " d4_en"},      32'(bus.d4_en), m_d4);
    check({tag, " cic_reset"},  32'(bus.cic_reset), 0);
    check({tag, " led"},        32'(bus.led), exp_region());
    check({tag, " pulses"},     pulse_count, m_pulses);
  endtask

  task automatic pad_bit(input logic pressed);
    bus.gamepad_data = ~pressed;
    @(negedge clk);
    bus.gamepad_clk = 1'b1;
    repeat (2) @(negedge clk);
    bus.gamepad_clk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [11:0] b, input int nbits);
    bus.gamepad_latch = 1'b1;
    repeat (2) @(negedge clk);
    bus.gamepad_latch = 1'b0;
    @(negedge clk);
    for (int i = 0; i < nbits; i++) pad_bit((i < 12) ? b[i] : 1'b0);
    bus.gamepad_data = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame(input string tag, input logic [11:0] b);
    bit fired;
    send_frame(b, 16);
    model_frame(b, fired);
    if (fired) begin
      repeat (RSTC + 8) @(negedge clk);
      check({tag, " pulse_width"}, last_width, RSTC);
    end
    check_state(tag);
  endtask

  task automatic hold(input string tag, input logic [11:0] b, input int n);
    for (int i = 0; i < n; i++) frame(tag, b);
  endtask

  initial begin
    bit fired;
    logic [11:0] b;
    logic [11:0] dirs [4];
    int len;

    dirs[0] = B_UP; dirs[1] = B_DOWN; dirs[2] = B_LEFT; dirs[3] = B_RIGHT;
    bus.gamepad_clk = 1'b0; bus.gamepad_latch = 1'b0; bus.gamepad_data = 1'b1;
    bus.cart_valid = 1'b0; bus.cart_region = 2'd0;
    m_pulses = 0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_state("reset");

    hold("right1", MASK | B_RIGHT, HOLD);
    frame("release", 12'h000);
    hold("right2", MASK | B_RIGHT, HOLD);
    frame("release", 12'h000);
    hold("right_wrap", MASK | B_RIGHT, HOLD);
    check("right_wrap idx", 32'(bus.region_out), 0);
    frame("release", 12'h000);
    hold("left_wrap", MASK | B_LEFT, HOLD);
    check("left_wrap idx", 32'(bus.region_out), NR - 1);
    frame("release", 12'h000);

    hold("short_hold", MASK | B_RIGHT, HOLD - 1);
    frame("short_release", 12'h000);

    hold("right3", MASK | B_RIGHT, HOLD);
    frame("release", 12'h000);
    hold("up_auto", MASK | B_UP, HOLD);
    frame("release", 12'h000);
    bus.cart_valid = 1'b1; bus.cart_region = 2'd2; #1;
    check("cart_follow", 32'(bus.region_out), exp_region());
    bus.cart_valid = 1'b0; #1;
    check("cart_invalid", 32'(bus.region_out), exp_region());
    bus.cart_valid = 1'b1; bus.cart_region = 2'd3; #1;
    check("cart_out_of_range", 32'(bus.region_out), exp_region());
    hold("left_clears_auto", MASK | B_LEFT, HOLD);
    frame("release", 12'h000);
    bus.cart_valid = 1'b0;

    hold("down_held", MASK | B_DOWN, 5 * HOLD);
    check("down d4_en", 32'(bus.d4_en), 0);
    frame("release", 12'h000);

    // Partial non-combo frame must not break a hold in progress.
    hold("partial_pre", MASK | B_RIGHT, HOLD - 1);
    send_frame(12'h000, 7);
    frame("partial_fire", MASK | B_RIGHT);
    frame("release", 12'h000);

    hold("rst_pre", MASK | B_RIGHT, HOLD - 1);
    send_frame(MASK | B_RIGHT, 16);
    model_frame(MASK | B_RIGHT, fired);
    repeat (5) @(negedge clk);
    check("mid_pulse cic_reset", 32'(bus.cic_reset), 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    m_pulses--;
    check("async_rst cic_reset", 32'(bus.cic_reset), 0);
    check("async_rst region_out", 32'(bus.region_out), DEFR);
    check("async_rst d4_en", 32'(bus.d4_en), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_state("after_rst");

    for (int k = 0; k < 25; k++) begin
      b = MASK | dirs[$urandom_range(0, 3)] | (12'($urandom) & 12'h303);
      len = $urandom_range(1, HOLD + 2);
      for (int i = 0; i < len; i++) begin
        bus.cart_valid  = 1'($urandom);
        bus.cart_region = 2'($urandom);
        frame("rand_hold", ($urandom_range(0, 7) == 0) ? 12'($urandom) : b);
      end
      frame("rand_after", ($urandom_range(0, 1) == 0) ? 12'h000 : 12'($urandom));
    end

    check("final pulses", pulse_count, m_pulses);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
